// File: rtl/wb_mem_arbiter_if.sv
// Wishbone bundle between the I/D masters, the arbiter and the shared line-wide memory port.
// slave modport: the arbiter's view (it serves the I and D masters and drives the memory port).
// master modport: the surrounding side (the masters' requests and the memory's response).
interface wb_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SEL_W  = DATA_W / 8
);
  logic              i_cyc;
  logic              i_stb;
  logic              i_we;
  logic [ADDR_W-1:0] i_adr;
  logic [SEL_W-1:0]  i_sel;
  logic [DATA_W-1:0] i_dat_m;
  logic [DATA_W-1:0] i_dat_s;
  logic              i_ack;

  logic              d_cyc;
  logic              d_stb;
  logic              d_we;
  logic [ADDR_W-1:0] d_adr;
  logic [SEL_W-1:0]  d_sel;
  logic [DATA_W-1:0] d_dat_m;
  logic [DATA_W-1:0] d_dat_s;
  logic              d_ack;

  logic              m_cyc;
  logic              m_stb;
  logic              m_we;
  logic [ADDR_W-1:0] m_adr;
  logic [SEL_W-1:0]  m_sel;
  logic [DATA_W-1:0] m_dat_m;
  logic [DATA_W-1:0] m_dat_s;
  logic              m_ack;

  modport slave (
    input  i_cyc, i_stb, i_we, i_adr, i_sel, i_dat_m,
    output i_dat_s, i_ack,
    input  d_cyc, d_stb, d_we, d_adr, d_sel, d_dat_m,
    output d_dat_s, d_ack,
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m,
    input  m_dat_s, m_ack
  );

  modport master (
    output i_cyc, i_stb, i_we, i_adr, i_sel, i_dat_m,
    input  i_dat_s, i_ack,
    output d_cyc, d_stb, d_we, d_adr, d_sel, d_dat_m,
    input  d_dat_s, d_ack,
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m,
    output m_dat_s, m_ack
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master wishbone arbiter for the shared 128-bit line memory port (ifetch I, data D).
// Registered grant FSM; the owner keeps the port until the slave acks or the owner drops cyc.
// On an ack, a pending request from the other master is granted with no idle gap.
// Build option ARB_ROUND_ROBIN_EN: idle ties go to the master not granted last (reset: D last,
// so the first tie goes to I). Without it, D always wins idle ties.
module wb_mem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SEL_W  = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_mem_arbiter_if.slave      bus,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e state_q, state_d;

  logic i_req, d_req;
  assign i_req = bus.i_cyc & bus.i_stb;
  assign d_req = bus.d_cyc & bus.d_stb;

  logic              cyc_mux, stb_mux, we_mux, i_ack_mux, d_ack_mux;
  logic [ADDR_W-1:0] adr_mux;
  logic [SEL_W-1:0]  sel_mux;
  logic [DATA_W-1:0] dat_mux;

`ifdef ARB_ROUND_ROBIN_EN
  // 1: D was granted most recently
  logic last_d_q, last_d_d;

  // Remember the most recent owner for idle tie-breaking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d_q <= 1'b1;
    else        last_d_q <= last_d_d;
  end
`endif

  // Grant state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state: arbitrate in idle, hand off or release on ack, release on abort
  always_comb begin
    state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_d_q ? StBusyI : StBusyD;
`else
          state_d = StBusyD;
`endif
        end else if (d_req) begin
          state_d = StBusyD;
        end else if (i_req) begin
          state_d = StBusyI;
        end
      end
      StBusyI: begin
        if (!bus.i_cyc)     state_d = StIdle;
        else if (bus.m_ack) state_d = d_req ? StBusyD : StIdle;
      end
      StBusyD: begin
        if (!bus.d_cyc)     state_d = StIdle;
        else if (bus.m_ack) state_d = i_req ? StBusyI : StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef ARB_ROUND_ROBIN_EN
    if (state_d == StBusyI)      last_d_d = 1'b0;
    else if (state_d == StBusyD) last_d_d = 1'b1;
`endif
  end

  // Route the owner's live bus signals to the slave and the slave ack back to the owner
  always_comb begin
    cyc_mux   = 1'b0;
    stb_mux   = 1'b0;
    we_mux    = 1'b0;
    i_ack_mux = 1'b0;
    d_ack_mux = 1'b0;
    // Address/data are don't-care while idle; the I inputs are used then
    adr_mux   = bus.i_adr;
    sel_mux   = bus.i_sel;
    dat_mux   = bus.i_dat_m;
    unique case (state_q)
      StBusyI: begin
        cyc_mux   = bus.i_cyc;
        stb_mux   = bus.i_stb;
        we_mux    = bus.i_we;
        i_ack_mux = bus.m_ack;
      end
      StBusyD: begin
        cyc_mux   = bus.d_cyc;
        stb_mux   = bus.d_stb;
        we_mux    = bus.d_we;
        adr_mux   = bus.d_adr;
        sel_mux   = bus.d_sel;
        dat_mux   = bus.d_dat_m;
        d_ack_mux = bus.m_ack;
      end
      default: ;
    endcase
  end

  assign bus.m_cyc   = cyc_mux;
  assign bus.m_stb   = stb_mux;
  assign bus.m_we    = we_mux;
  assign bus.m_adr   = adr_mux;
  assign bus.m_sel   = sel_mux;
  assign bus.m_dat_m = dat_mux;
  assign bus.i_ack   = i_ack_mux;
  assign bus.d_ack   = d_ack_mux;

  // Read data fans out unqualified; only the ack marks it valid
  assign bus.i_dat_s = bus.m_dat_s;
  assign bus.d_dat_s = bus.m_dat_s;

  // Registered one-hot {D,I} owner
  assign grant = {state_q == StBusyD, state_q == StBusyI};

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed transactions with literal expectations plus an
// owner-tracking model compared against the DUT on every negative clock edge out of reset.
module tb_wb_mem_arbiter;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned SEL_W  = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model: 0 = nobody owns the port, 1 = I, 2 = D
  int owner = 0;
  int last  = 2;

  wb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  wb_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Model update: who owns the port after this edge
  always @(posedge clk or negedge rst_n) begin
    bit ir, dr;
    if (!rst_n) begin
      owner = 0;
      last  = 2;
    end else begin
      ir = bus.i_cyc & bus.i_stb;
      dr = bus.d_cyc & bus.d_stb;
      if (owner == 0) begin
        if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
          owner = (last == 2) ? 1 : 2;
`else
          owner = 2;
`endif
        end else if (dr) owner = 2;
        else if (ir)     owner = 1;
      end else if (owner == 1) begin
        if (!bus.i_cyc)     owner = 0;
        else if (bus.m_ack) owner = dr ? 2 : 0;
      end else begin
        if (!bus.d_cyc)     owner = 0;
        else if (bus.m_ack) owner = ir ? 1 : 0;
      end
      if (owner != 0) last = owner;
    end
  end

  // Compare DUT outputs with what the current owner implies
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_grant", grant, (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
      chk("m_cyc", bus.m_cyc, (owner == 1) ? bus.i_cyc : (owner == 2) ? bus.d_cyc : 1'b0);
      chk("m_stb", bus.m_stb, (owner == 1) ? bus.i_stb : (owner == 2) ? bus.d_stb : 1'b0);
      chk("m_we", bus.m_we, (owner == 1) ? bus.i_we : (owner == 2) ? bus.d_we : 1'b0);
      chk("m_i_ack", bus.i_ack, (owner == 1) ? bus.m_ack : 1'b0);
      chk("m_d_ack", bus.d_ack, (owner == 2) ? bus.m_ack : 1'b0);
      chk("m_i_dat_s", bus.i_dat_s, bus.m_dat_s);
      chk("m_d_dat_s", bus.d_dat_s, bus.m_dat_s);
      if (owner != 0) begin
        chk("m_adr", bus.m_adr, (owner == 1) ? bus.i_adr : bus.d_adr);
        chk("m_sel", bus.m_sel, (owner == 1) ? bus.i_sel : bus.d_sel);
        chk("m_dat_m", bus.m_dat_m, (owner == 1) ? bus.i_dat_m : bus.d_dat_m);
      end
    end
  end

  task automatic clear_inputs();
    bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0; bus.i_adr = '0; bus.i_sel = '0;
    bus.i_dat_m = '0;
    bus.d_cyc = 0; bus.d_stb = 0; bus.d_we = 0; bus.d_adr = '0; bus.d_sel = '0;
    bus.d_dat_m = '0;
    bus.m_ack = 0; bus.m_dat_s = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic i_req(input logic [11:0] adr);
    bus.i_cyc = 1; bus.i_stb = 1; bus.i_adr = adr; bus.i_sel = 16'hFFFF;
  endtask

  task automatic d_req(input logic [11:0] adr);
    bus.d_cyc = 1; bus.d_stb = 1; bus.d_adr = adr; bus.d_sel = 16'hFFFF;
  endtask

  // Both masters request together; first is the expected winner, the other follows on its ack
  task automatic tie_round(input logic [1:0] first);
    logic [1:0] second;
    second = ~first;
    tick();
    i_req(12'h111);
    d_req(12'h222);
    @(negedge clk); chk("tie_latency", grant, 2'b00);
    tick();
    @(negedge clk); chk("tie_first", grant, first);
    tick();
    bus.m_ack = 1;
    @(negedge clk); chk("tie_first_ack", {bus.d_ack, bus.i_ack}, first);
    tick();
    bus.m_ack = 0;
    if (first == 2'b01) begin bus.i_cyc = 0; bus.i_stb = 0; end
    else begin bus.d_cyc = 0; bus.d_stb = 0; end
    @(negedge clk); chk("tie_handoff", grant, second);
    tick();
    bus.m_ack = 1;
    @(negedge clk); chk("tie_second_ack", {bus.d_ack, bus.i_ack}, second);
    tick();
    clear_inputs();
    @(negedge clk); chk("tie_idle", grant, 2'b00);
  endtask

  initial begin
    logic [127:0] rd_line;
    logic [127:0] wr_line;
    logic [1:0]   tie_first;
    rd_line = {4{32'hA5A5A5A5}};
    wr_line = {32'h01234567, 32'hDEADBEEF, 32'h89ABCDEF, 32'h0BADF00D};
`ifdef ARB_ROUND_ROBIN_EN
    tie_first = 2'b01;
`else
    tie_first = 2'b10;
`endif

    // Reset with a stray ack present: nothing may be granted or acked
    rst_n = 0;
    clear_inputs();
    bus.m_ack = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_m_cyc", bus.m_cyc, 1'b0);
    chk("rst_acks", {bus.d_ack, bus.i_ack}, 2'b00);
    bus.m_ack = 0;
    rst_n = 1;

    // Single I read
    tick();
    i_req(12'h010);
    @(negedge clk); chk("rd_latency", grant, 2'b00);
    tick();
    @(negedge clk);
    chk("rd_grant", grant, 2'b01);
    chk("rd_adr", bus.m_adr, 12'h010);
    chk("rd_we", bus.m_we, 1'b0);
    tick();
    tick();
    bus.m_ack = 1; bus.m_dat_s = rd_line;
    @(negedge clk);
    chk("rd_i_ack", bus.i_ack, 1'b1);
    chk("rd_i_dat", bus.i_dat_s, rd_line);
    chk("rd_d_ack", bus.d_ack, 1'b0);
    tick();
    clear_inputs();
    @(negedge clk); chk("rd_release", grant, 2'b00);

    // D write
    tick();
    d_req(12'h2A0);
    bus.d_we = 1; bus.d_sel = 16'h0030; bus.d_dat_m = wr_line;
    tick();
    @(negedge clk);
    chk("wr_we", bus.m_we, 1'b1);
    chk("wr_sel", bus.m_sel, 16'h0030);
    chk("wr_dat", bus.m_dat_m, wr_line);
    tick();
    bus.m_ack = 1;
    @(negedge clk); chk("wr_acks", {bus.d_ack, bus.i_ack}, 2'b10);
    tick();
    clear_inputs();
    @(negedge clk); chk("wr_release", {grant, bus.d_ack}, 3'b000);

    // Asynchronous reset while I is mid-transfer and acked
    tick();
    i_req(12'h055);
    tick();
    @(negedge clk); chk("ar_grant", grant, 2'b01);
    tick();
    bus.m_ack = 1;
    #2 rst_n = 0;
    #1;
    chk("ar_i_ack", bus.i_ack, 1'b0);
    chk("ar_m_cyc", bus.m_cyc, 1'b0);
    chk("ar_grant_async", grant, 2'b00);
    clear_inputs();
    @(posedge clk);
    #3 rst_n = 1;

    // Ties: winner depends on build; loser follows directly on the ack
    tie_round(tie_first);
    tie_round(tie_first);

    // Abort by D with I waiting, then a stray ack while idle
    tick();
    d_req(12'h333);
    tick();
    i_req(12'h044);
    @(negedge clk); chk("ab_grant_d", grant, 2'b10);
    tick();
    bus.d_cyc = 0; bus.d_stb = 0;
    @(negedge clk);
    chk("ab_m_cyc", bus.m_cyc, 1'b0);
    chk("ab_still_d", grant, 2'b10);
    tick();
    bus.m_ack = 1;
    @(negedge clk);
    chk("ab_idle", grant, 2'b00);
    chk("ab_stray_ack", {bus.d_ack, bus.i_ack}, 2'b00);
    tick();
    bus.m_ack = 0;
    @(negedge clk);
    chk("ab_grant_i", grant, 2'b01);
    chk("ab_adr_i", bus.m_adr, 12'h044);
    tick();
    bus.m_ack = 1;
    tick();
    clear_inputs();
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
